// File: rtl/key_event_dispatcher.sv
// Key event dispatcher: tracks held game keys, filters typematic repeats and
// queues press/release events in a FWFT FIFO for a single valid/ready consumer.
module key_event_dispatcher #(
  parameter int                      DEPTH         = 4,
  parameter int                      NUM_KEYS      = 8,
  parameter logic [9*NUM_KEYS-1:0]   KEY_TABLE     = {9'h076, 9'h04D, 9'h05A, 9'h029,
                                                      9'h172, 9'h175, 9'h174, 9'h16B},
  parameter logic                    FILTER_REPEAT = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       make,
  input  logic                       brakk,
  input  logic [8:0]                 keyCode,
  input  logic                       flush,
  input  logic                       ev_ready,
  output logic                       ev_valid,
  output logic [8:0]                 ev_code,
  output logic                       ev_is_make,
  output logic [NUM_KEYS-1:0]        held,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [7:0]                 overflow_cnt,
  output logic [1:0]                 dbg_status
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FILTERED = 2'd1,
    ST_PUSH     = 2'd2,
    ST_DROP     = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [9:0]          mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                ev_valid_q, ev_valid_d;
  logic [8:0]          ev_code_q, ev_code_d;
  logic                ev_make_q, ev_make_d;
  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [7:0]          ovf_q, ovf_d;

  logic [NUM_KEYS-1:0] match_s;
  logic                event_s;
  logic                repeat_s;
  logic                full_s;
  logic                pop_s;
  logic                push_s;
  logic [9:0]          entry_s;

  // Key table lookup; duplicate entries all match.
  always_comb begin
    match_s = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      match_s[i] = (keyCode == KEY_TABLE[9*i +: 9]);
    end
  end

  assign event_s  = make | brakk;
  assign entry_s  = {make, keyCode};
  assign repeat_s = FILTER_REPEAT & make & (|(match_s & held_q));
  assign full_s   = (count_q == CNT_FULL);
  assign pop_s    = ev_valid_q & ev_ready;

  // Event classification, held bitmap, FIFO bookkeeping and head prefetch.
  always_comb begin
    state_d    = ST_IDLE;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    ev_valid_d = ev_valid_q;
    ev_code_d  = ev_code_q;
    ev_make_d  = ev_make_q;
    held_d     = held_q;
    push_s     = 1'b0;

    for (int i = 0; i < NUM_KEYS; i++) begin
      if (match_s[i] && make) begin
        held_d[i] = 1'b1;
      end else if (match_s[i] && brakk) begin
        held_d[i] = 1'b0;
      end else begin
        held_d[i] = held_q[i];
      end
    end

    if (!event_s) begin
      state_d = ST_IDLE;
    end else if (flush || repeat_s) begin
      state_d = ST_FILTERED;
    end else if (!full_s || pop_s) begin
      state_d = ST_PUSH;
    end else begin
      state_d = ST_DROP;
    end

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = CNT_ZERO;
      ev_valid_d = 1'b0;
    end else begin
      push_s = (state_d == ST_PUSH);
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if ((state_d == ST_DROP) && (ovf_q != 8'hFF)) begin
        ovf_d = ovf_q + 8'd1;
      end else begin
        ovf_d = ovf_q;
      end
      // The new head bypasses memory when it is the entry being written now.
      if (count_d != CNT_ZERO) begin
        ev_valid_d = 1'b1;
        if (push_s && (rd_ptr_d == wr_ptr_q)) begin
          {ev_make_d, ev_code_d} = entry_s;
        end else begin
          {ev_make_d, ev_code_d} = mem_q[rd_ptr_d];
        end
      end else begin
        ev_valid_d = 1'b0;
      end
    end
  end

  // Status, pointer, occupancy and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= CNT_ZERO;
      ev_valid_q <= 1'b0;
      ev_code_q  <= 9'h000;
      ev_make_q  <= 1'b0;
      held_q     <= '0;
      ovf_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ev_valid_q <= ev_valid_d;
      ev_code_q  <= ev_code_d;
      ev_make_q  <= ev_make_d;
      held_q     <= held_d;
      ovf_q      <= ovf_d;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 10'h000;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= entry_s;
    end
  end

  assign ev_valid     = ev_valid_q;
  assign ev_code      = ev_code_q;
  assign ev_is_make   = ev_make_q;
  assign held         = held_q;
  assign fifo_count   = count_q;
  assign overflow_cnt = ovf_q;
  assign dbg_status   = state_q;

endmodule

// File: tb/tb_key_event_dispatcher.sv
// Randomized and directed bench for key_event_dispatcher against a queue-based
// reference model of the event rules.
module tb_key_event_dispatcher;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       make = 1'b0;
  logic       brakk = 1'b0;
  logic [8:0] keyCode = 9'h000;
  logic       flush = 1'b0;
  logic       ev_ready = 1'b0;
  logic       ev_valid;
  logic [8:0] ev_code;
  logic       ev_is_make;
  logic [7:0] held;
  logic [2:0] fifo_count;
  logic [7:0] overflow_cnt;
  logic [1:0] dbg_status;

  int total = 0;
  int bad = 0;

  logic [8:0] keys [8] = '{9'h16B, 9'h174, 9'h175, 9'h172, 9'h029, 9'h05A, 9'h04D, 9'h076};
  logic [9:0] m_q [$];
  logic [7:0] m_held;
  int         m_ov;
  logic [9:0] m_last;

  key_event_dispatcher dut (
    .clk(clk), .reset(reset), .make(make), .brakk(brakk), .keyCode(keyCode),
    .flush(flush), .ev_ready(ev_ready), .ev_valid(ev_valid), .ev_code(ev_code),
    .ev_is_make(ev_is_make), .held(held), .fifo_count(fifo_count),
    .overflow_cnt(overflow_cnt), .dbg_status(dbg_status)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_q.delete();
    m_held = 8'h00;
    m_ov   = 0;
    m_last = 10'h000;
  endtask

  task automatic model_step();
    logic [7:0] m;
    bit filt, pop;
    m = 8'h00;
    for (int k = 0; k < 8; k++) if (keyCode == keys[k]) m[k] = 1'b1;
    pop  = (m_q.size() > 0) && ev_ready;
    filt = make && ((m & m_held) != 8'h00);
    if (make) m_held = m_held | m;
    else if (brakk) m_held = m_held & ~m;
    if (flush) begin
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if ((make || brakk) && !filt) begin
        if (m_q.size() < 4) m_q.push_back({make, keyCode});
        else if (m_ov < 255) m_ov++;
      end
    end
    if (m_q.size() > 0) m_last = m_q[0];
  endtask

  task automatic cycle(input logic mk, input logic br, input logic [8:0] kc,
                       input logic fl, input logic rdy);
    @(negedge clk);
    make = mk; brakk = br; keyCode = kc; flush = fl; ev_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
    make = 1'b0; brakk = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    make = 1'b0; brakk = 1'b0; flush = 1'b0; ev_ready = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", ev_valid); end
    total++; if ({ev_is_make, ev_code} !== 10'h000) begin bad++; $display("FAIL reset_head got=%h want=000", {ev_is_make, ev_code}); end
    total++; if (held !== 8'h00) begin bad++; $display("FAIL reset_held got=%h want=00", held); end
    total++; if ({fifo_count, overflow_cnt} !== 11'h000) begin bad++; $display("FAIL reset_counts got=%h want=000", {fifo_count, overflow_cnt}); end
  endtask

  task automatic test_basic();
    do_reset();
    cycle(1'b1, 1'b0, 9'h16B, 1'b0, 1'b0);
    total++; if (held !== 8'h01) begin bad++; $display("FAIL basic_held got=%h want=01", held); end
    total++; if ({ev_valid, ev_is_make, ev_code} !== {1'b1, 1'b1, 9'h16B}) begin bad++; $display("FAIL basic_head got=%b/%b/%h want=1/1/16b", ev_valid, ev_is_make, ev_code); end
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL basic_count got=%0d want=1", fifo_count); end
  endtask

  task automatic test_repeat();
    do_reset();
    cycle(1'b1, 1'b0, 9'h029, 1'b0, 1'b0);
    total++; if (held !== 8'h10) begin bad++; $display("FAIL repeat_held_set got=%h want=10", held); end
    cycle(1'b1, 1'b0, 9'h029, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 9'h029, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 9'h029, 1'b0, 1'b0);
    total++; if (held !== 8'h00) begin bad++; $display("FAIL repeat_held_clr got=%h want=00", held); end
    total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL repeat_count got=%0d want=2", fifo_count); end
    total++; if ({ev_is_make, ev_code} !== {1'b1, 9'h029}) begin bad++; $display("FAIL repeat_first got=%b/%h want=1/029", ev_is_make, ev_code); end
    cycle(1'b0, 1'b0, 9'h000, 1'b0, 1'b1);
    total++; if ({ev_valid, ev_is_make, ev_code} !== {1'b1, 1'b0, 9'h029}) begin bad++; $display("FAIL repeat_second got=%b/%b/%h want=1/0/029", ev_valid, ev_is_make, ev_code); end
    total++; if (overflow_cnt !== 8'd0) begin bad++; $display("FAIL repeat_ovf got=%0d want=0", overflow_cnt); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 9'h01C + 9'(i), 1'b0, 1'b0);
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d want=4", fifo_count); end
    total++; if (overflow_cnt !== 8'd2) begin bad++; $display("FAIL ovf_cnt got=%0d want=2", overflow_cnt); end
    for (int i = 0; i < 4; i++) begin
      total++; if ({ev_valid, ev_code} !== {1'b1, 9'h01C + 9'(i)}) begin bad++; $display("FAIL ovf_drain%0d got=%b/%h want=1/%h", i, ev_valid, ev_code, 9'h01C + 9'(i)); end
      cycle(1'b0, 1'b0, 9'h000, 1'b0, 1'b1);
    end
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b want=0", ev_valid); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_codes [4];
    exp_codes = '{9'h01D, 9'h01E, 9'h01F, 9'h05A};
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 9'h01C + 9'(i), 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 9'h05A, 1'b0, 1'b1);
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL b2b_count got=%0d want=4", fifo_count); end
    total++; if (overflow_cnt !== 8'd0) begin bad++; $display("FAIL b2b_ovf got=%0d want=0", overflow_cnt); end
    for (int i = 0; i < 4; i++) begin
      total++; if (ev_code !== exp_codes[i]) begin bad++; $display("FAIL b2b_drain%0d got=%h want=%h", i, ev_code, exp_codes[i]); end
      cycle(1'b0, 1'b0, 9'h000, 1'b0, 1'b1);
    end
  endtask

  task automatic test_flush();
    do_reset();
    cycle(1'b1, 1'b0, 9'h16B, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 9'h01C + 9'(i), 1'b0, 1'b0);
    total++; if ({held[0], overflow_cnt} !== {1'b1, 8'd1}) begin bad++; $display("FAIL flush_pre got=%b/%0d want=1/1", held[0], overflow_cnt); end
    cycle(1'b0, 1'b1, 9'h16B, 1'b1, 1'b0);
    total++; if ({ev_valid, fifo_count} !== {1'b0, 3'd0}) begin bad++; $display("FAIL flush_empty got=%b/%0d want=0/0", ev_valid, fifo_count); end
    total++; if (held[0] !== 1'b0) begin bad++; $display("FAIL flush_held got=%b want=0", held[0]); end
    total++; if (overflow_cnt !== 8'd1) begin bad++; $display("FAIL flush_ovf got=%0d want=1", overflow_cnt); end
    total++; if (ev_code !== 9'h16B) begin bad++; $display("FAIL flush_hold got=%h want=16b", ev_code); end
  endtask

  task automatic test_midreset();
    do_reset();
    cycle(1'b1, 1'b0, 9'h16B, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 9'h175, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 9'h01C, 1'b0, 1'b0);
    total++; if ({held, fifo_count} !== {8'h05, 3'd3}) begin bad++; $display("FAIL midrst_pre got=%h/%0d want=05/3", held, fifo_count); end
    #2 reset = 1'b1;
    #1;
    total++; if ({ev_valid, ev_is_make, ev_code, held, fifo_count, overflow_cnt} !== 29'h0) begin bad++; $display("FAIL midrst_clear got=%h want=0", {ev_valid, ev_is_make, ev_code, held, fifo_count, overflow_cnt}); end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 1'b0, 9'h174, 1'b0, 1'b0);
    total++; if ({ev_valid, ev_is_make, ev_code, held, fifo_count} !== {1'b1, 1'b1, 9'h174, 8'h02, 3'd1}) begin bad++; $display("FAIL midrst_after got=%b/%b/%h/%h/%0d want=1/1/174/02/1", ev_valid, ev_is_make, ev_code, held, fifo_count); end
  endtask

  task automatic test_random();
    logic mk, br, fl, rdy;
    logic [8:0] kc;
    logic [28:0] exp_v, got_v;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      mk  = ($urandom_range(0, 99) < 40);
      br  = ($urandom_range(0, 99) < 30);
      fl  = ($urandom_range(0, 99) < 3);
      rdy = ($urandom_range(0, 99) < 35);
      kc  = ($urandom_range(0, 1) == 0) ? keys[$urandom_range(0, 7)] : 9'($urandom);
      cycle(mk, br, kc, fl, rdy);
      exp_v = {m_q.size() > 0, m_last, m_held, 3'(m_q.size()), 8'(m_ov)};
      got_v = {ev_valid, ev_is_make, ev_code, held, fifo_count, overflow_cnt};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL random_cycle%0d got=%h want=%h", n, got_v, exp_v);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_repeat();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
